// File: rtl/osd_box_overlay_if.sv
// Video stream and box-control bundle for osd_box_overlay.
// The master side is the upstream timing generator plus box-control logic;
// the slave side is the overlay block.
interface osd_box_overlay_if;
    // Upstream video
    logic        i_hs;
    logic        i_vs;
    logic        i_de;
    logic [7:0]  i_r;
    logic [7:0]  i_g;
    logic [7:0]  i_b;
    logic [11:0] i_x;
    logic [11:0] i_y;

    // Box control
    logic [11:0] box_x0;
    logic [11:0] box_y0;
    logic [11:0] box_x1;
    logic [11:0] box_y1;
    logic        box_en;
    logic        box_wr;

    // Downstream video and status
    logic        o_hs;
    logic        o_vs;
    logic        o_de;
    logic [7:0]  o_r;
    logic [7:0]  o_g;
    logic [7:0]  o_b;
    logic        box_pending;
    logic [15:0] frame_cnt;

    modport master (
        output i_hs, i_vs, i_de, i_r, i_g, i_b, i_x, i_y,
        output box_x0, box_y0, box_x1, box_y1, box_en, box_wr,
        input  o_hs, o_vs, o_de, o_r, o_g, o_b, box_pending, frame_cnt
    );

    modport slave (
        input  i_hs, i_vs, i_de, i_r, i_g, i_b, i_x, i_y,
        input  box_x0, box_y0, box_x1, box_y1, box_en, box_wr,
        output o_hs, o_vs, o_de, o_r, o_g, o_b, box_pending, frame_cnt
    );
endinterface

// File: rtl/osd_box_overlay.sv
// Bounding-box outline overlay for the HDMI video path.
// Box corners are written at any time into pending registers and are only
// applied to the active box at frame start, so a box never tears mid-frame.
// Video passes through with a fixed 2-cycle latency.
// Optional feature: define OSD_CROSSHAIR_EN to also draw a crosshair through
// the box centre in CROSS_RGB, drawn on top of the outline.
module osd_box_overlay #(
    parameter int unsigned BORDER_W  = 2,
    parameter logic [23:0] BOX_RGB   = 24'hFF0000,
    parameter logic        VS_POL    = 1'b1,
    parameter logic [23:0] CROSS_RGB = 24'h00FF00
) (
    input logic               clk,
    input logic               rst,
    osd_box_overlay_if.slave  bus
);

    localparam logic [12:0] BW  = 13'(BORDER_W);
    localparam logic [12:0] BW2 = 13'(2 * BORDER_W);

    // Elaboration-time parameter sanity
    if (BORDER_W < 1 || BORDER_W > 15) begin : g_bad_border
        $error("BORDER_W must be in 1..15");
    end
    if (CROSS_RGB == BOX_RGB) begin : g_same_rgb
        $warning("CROSS_RGB equals BOX_RGB; crosshair will not stand out");
    end

    // Frame-start detection
    logic vs_q;
    logic fs;
    assign fs = (bus.i_vs == VS_POL) && (vs_q != VS_POL);

    // Pending box
    logic [11:0] pend_x0_q, pend_y0_q, pend_x1_q, pend_y1_q;
    logic        pend_en_q;
    logic        pending_q;

    // Active box (normalised)
    logic [11:0] act_xl_q, act_xr_q, act_yt_q, act_yb_q;
    logic        act_en_q;
    logic        act_empty_q;

    // Normalised view of the pending box
    logic [11:0] n_xl, n_xr, n_yt, n_yb;
    logic [12:0] n_w, n_h;
    logic        n_empty;

    // Hit test
    logic [12:0] x13, y13;
    logic [12:0] in_xl, in_xr, in_yt, in_yb;
    logic        outer, inner;

    // Pipeline
    logic        s1_hs_q, s1_vs_q, s1_de_q;
    logic [23:0] s1_rgb_q;
    logic        s1_outer_q, s1_inner_q;
    logic        o_hs_q, o_vs_q, o_de_q;
    logic [23:0] o_rgb_q;
    logic [23:0] out_rgb_d;
    logic [15:0] frame_cnt_q;

`ifdef OSD_CROSSHAIR_EN
    logic [12:0] n_cx_sum, n_cy_sum;
    logic [11:0] act_cx_q, act_cy_q;
    logic        cross;
    logic        s1_cross_q;
`endif

    // Sort corners and decide whether the interior is too small to exist
    always_comb begin
        n_xl    = (pend_x0_q <= pend_x1_q) ? pend_x0_q : pend_x1_q;
        n_xr    = (pend_x0_q <= pend_x1_q) ? pend_x1_q : pend_x0_q;
        n_yt    = (pend_y0_q <= pend_y1_q) ? pend_y0_q : pend_y1_q;
        n_yb    = (pend_y0_q <= pend_y1_q) ? pend_y1_q : pend_y0_q;
        n_w     = {1'b0, n_xr} - {1'b0, n_xl} + 13'd1;
        n_h     = {1'b0, n_yb} - {1'b0, n_yt} + 13'd1;
        // An empty interior also guards the underflow of xr-BORDER_W below
        n_empty = (n_w <= BW2) || (n_h <= BW2);
    end

`ifdef OSD_CROSSHAIR_EN
    assign n_cx_sum = {1'b0, n_xl} + {1'b0, n_xr};
    assign n_cy_sum = {1'b0, n_yt} + {1'b0, n_yb};
`endif

    // Registered vsync history for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q <= ~VS_POL;
        end else begin
            vs_q <= bus.i_vs;
        end
    end

    // Pending registers: a write always wins the pending slot, fs only clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_x0_q <= '0;
            pend_y0_q <= '0;
            pend_x1_q <= '0;
            pend_y1_q <= '0;
            pend_en_q <= 1'b0;
            pending_q <= 1'b0;
        end else if (bus.box_wr) begin
            pend_x0_q <= bus.box_x0;
            pend_y0_q <= bus.box_y0;
            pend_x1_q <= bus.box_x1;
            pend_y1_q <= bus.box_y1;
            pend_en_q <= bus.box_en;
            pending_q <= 1'b1;
        end else if (fs) begin
            pending_q <= 1'b0;
        end
    end

    // Active box: loaded from the pre-write pending contents at frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            act_xl_q    <= '0;
            act_xr_q    <= '0;
            act_yt_q    <= '0;
            act_yb_q    <= '0;
            act_en_q    <= 1'b0;
            act_empty_q <= 1'b0;
`ifdef OSD_CROSSHAIR_EN
            act_cx_q    <= '0;
            act_cy_q    <= '0;
`endif
        end else if (fs && pending_q) begin
            act_xl_q    <= n_xl;
            act_xr_q    <= n_xr;
            act_yt_q    <= n_yt;
            act_yb_q    <= n_yb;
            act_en_q    <= pend_en_q;
            act_empty_q <= n_empty;
`ifdef OSD_CROSSHAIR_EN
            act_cx_q    <= n_cx_sum[12:1];
            act_cy_q    <= n_cy_sum[12:1];
`endif
        end
    end

    // Frame counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (fs) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    // Outer/inner rectangle membership of the current pixel
    always_comb begin
        x13   = {1'b0, bus.i_x};
        y13   = {1'b0, bus.i_y};
        in_xl = {1'b0, act_xl_q} + BW;
        in_xr = {1'b0, act_xr_q} - BW;
        in_yt = {1'b0, act_yt_q} + BW;
        in_yb = {1'b0, act_yb_q} - BW;
        outer = (bus.i_x >= act_xl_q) && (bus.i_x <= act_xr_q) &&
                (bus.i_y >= act_yt_q) && (bus.i_y <= act_yb_q);
        inner = !act_empty_q &&
                (x13 >= in_xl) && (x13 <= in_xr) &&
                (y13 >= in_yt) && (y13 <= in_yb);
    end

`ifdef OSD_CROSSHAIR_EN
    assign cross = (bus.i_x == act_cx_q) || (bus.i_y == act_cy_q);
`endif

    // Stage 1: hit flags, input pixel and timing
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hs_q    <= 1'b0;
            s1_vs_q    <= 1'b0;
            s1_de_q    <= 1'b0;
            s1_rgb_q   <= '0;
            s1_outer_q <= 1'b0;
            s1_inner_q <= 1'b0;
`ifdef OSD_CROSSHAIR_EN
            s1_cross_q <= 1'b0;
`endif
        end else begin
            s1_hs_q    <= bus.i_hs;
            s1_vs_q    <= bus.i_vs;
            s1_de_q    <= bus.i_de;
            s1_rgb_q   <= {bus.i_r, bus.i_g, bus.i_b};
            s1_outer_q <= act_en_q && outer;
            s1_inner_q <= inner;
`ifdef OSD_CROSSHAIR_EN
            s1_cross_q <= act_en_q && outer && cross;
`endif
        end
    end

    // Output colour select: blanking, crosshair, outline, passthrough
    always_comb begin
        out_rgb_d = s1_rgb_q;
        if (!s1_de_q) begin
            out_rgb_d = '0;
`ifdef OSD_CROSSHAIR_EN
        end else if (s1_cross_q) begin
            out_rgb_d = CROSS_RGB;
`endif
        end else if (s1_outer_q && !s1_inner_q) begin
            out_rgb_d = BOX_RGB;
        end
    end

    // Stage 2: output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            o_hs_q  <= 1'b0;
            o_vs_q  <= 1'b0;
            o_de_q  <= 1'b0;
            o_rgb_q <= '0;
        end else begin
            o_hs_q  <= s1_hs_q;
            o_vs_q  <= s1_vs_q;
            o_de_q  <= s1_de_q;
            o_rgb_q <= out_rgb_d;
        end
    end

    assign bus.o_hs        = o_hs_q;
    assign bus.o_vs        = o_vs_q;
    assign bus.o_de        = o_de_q;
    assign bus.o_r         = o_rgb_q[23:16];
    assign bus.o_g         = o_rgb_q[15:8];
    assign bus.o_b         = o_rgb_q[7:0];
    assign bus.box_pending = pending_q;
    assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_osd_box_overlay.sv
// Directed bench for osd_box_overlay with hand-computed expected pixels.
// Honours OSD_CROSSHAIR_EN for the expected colours.
module tb_osd_box_overlay;

    localparam logic [23:0] BG    = 24'h101010;
    localparam logic [23:0] BOX   = 24'hFF0000;
    localparam logic [23:0] CROSS = 24'h00FF00;
`ifdef OSD_CROSSHAIR_EN
    localparam bit XH = 1'b1;
`else
    localparam bit XH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_fc   = 0;

    always #5 clk = ~clk;

    osd_box_overlay_if bus ();

    osd_box_overlay dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One active pixel followed by a blank; compare 2 cycles after drive
    task automatic pixel(input string tag, input int x, input int y, input logic [23:0] exp);
        bus.i_de = 1'b1;
        bus.i_x  = 12'(x);
        bus.i_y  = 12'(y);
        {bus.i_r, bus.i_g, bus.i_b} = BG;
        step();
        bus.i_de = 1'b0;
        bus.i_x  = 12'hFFF;
        bus.i_y  = 12'hFFF;
        step();
        check(tag, {8'h00, bus.o_r, bus.o_g, bus.o_b}, {8'h00, exp});
    endtask

    task automatic set_box(input int x0, input int y0, input int x1, input int y1,
                           input bit en);
        bus.box_x0 = 12'(x0);
        bus.box_y0 = 12'(y0);
        bus.box_x1 = 12'(x1);
        bus.box_y1 = 12'(y1);
        bus.box_en = en;
    endtask

    task automatic write_box(input int x0, input int y0, input int x1, input int y1,
                             input bit en);
        set_box(x0, y0, x1, y1, en);
        bus.box_wr = 1'b1;
        step();
        bus.box_wr = 1'b0;
    endtask

    // Vsync pulse; optionally a box write lands on the fs cycle itself
    task automatic frame_start(input bit wr, input int x0, input int y0, input int x1,
                               input int y1, input bit en);
        bus.i_vs = 1'b1;
        if (wr) begin
            set_box(x0, y0, x1, y1, en);
            bus.box_wr = 1'b1;
        end
        step();
        bus.box_wr = 1'b0;
        step();
        bus.i_vs = 1'b0;
        step();
        exp_fc++;
    endtask

    initial begin
        logic [7:0] de_pat;
        logic [7:0] hs_pat;
        de_pat = 8'b1011_0010;
        hs_pat = 8'b0110_1001;

        rst        = 1'b1;
        bus.i_hs   = 1'b0;
        bus.i_vs   = 1'b0;
        bus.i_de   = 1'b0;
        bus.i_r    = 8'h10;
        bus.i_g    = 8'h10;
        bus.i_b    = 8'h10;
        bus.i_x    = 12'hFFF;
        bus.i_y    = 12'hFFF;
        bus.box_wr = 1'b0;
        set_box(0, 0, 0, 0, 1'b0);
        step();
        step();
        rst = 1'b0;

        // Run an active line, then reset in the middle of it
        bus.i_de = 1'b1;
        bus.i_hs = 1'b1;
        bus.i_x  = 12'd5;
        bus.i_y  = 12'd5;
        repeat (3) step();
        rst = 1'b1;
        repeat (4) step();
        check("rst_o_de", 32'(bus.o_de), 32'd0);
        check("rst_o_hs", 32'(bus.o_hs), 32'd0);
        check("rst_o_vs", 32'(bus.o_vs), 32'd0);
        check("rst_rgb", {8'h00, bus.o_r, bus.o_g, bus.o_b}, 32'd0);
        check("rst_pending", 32'(bus.box_pending), 32'd0);
        check("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        rst = 1'b0;

        // o_de/o_hs trail the inputs by exactly 2 cycles
        for (int k = 0; k < 10; k++) begin
            if (k >= 2) begin
                check($sformatf("de_delay_%0d", k), 32'(bus.o_de), 32'(de_pat[k-2]));
                check($sformatf("hs_delay_%0d", k), 32'(bus.o_hs), 32'(hs_pat[k-2]));
            end
            bus.i_de = (k < 8) ? de_pat[k] : 1'b0;
            bus.i_hs = (k < 8) ? hs_pat[k] : 1'b0;
            step();
        end
        bus.i_de = 1'b0;
        bus.i_hs = 1'b0;
        bus.i_x  = 12'hFFF;
        bus.i_y  = 12'hFFF;

        // Basic outline
        write_box(100, 50, 200, 150, 1'b1);
        check("basic_pending_set", 32'(bus.box_pending), 32'd1);
        pixel("no_box_yet", 100, 50, BG);
        frame_start(1'b0, 0, 0, 0, 0, 1'b0);
        check("basic_pending_clr", 32'(bus.box_pending), 32'd0);
        check("basic_fc", 32'(bus.frame_cnt), 32'(exp_fc));
        pixel("basic_100_50", 100, 50, BOX);
        pixel("basic_101_100", 101, 100, XH ? CROSS : BOX);
        pixel("basic_102_100", 102, 100, XH ? CROSS : BG);
        pixel("basic_201_100", 201, 100, BG);
        pixel("basic_200_150", 200, 150, BOX);
        pixel("basic_102_120", 102, 120, BG);
        pixel("basic_150_80", 150, 80, XH ? CROSS : BG);
        pixel("basic_100_100", 100, 100, XH ? CROSS : BOX);
        pixel("basic_99_100", 99, 100, BG);

        // Blanked pixel inside the box must be black
        bus.i_de = 1'b0;
        bus.i_x  = 12'd100;
        bus.i_y  = 12'd50;
        step();
        bus.i_x = 12'hFFF;
        bus.i_y = 12'hFFF;
        step();
        check("blank_black", {8'h00, bus.o_r, bus.o_g, bus.o_b}, 32'd0);

        // Shadowing: mid-frame write does not disturb the current frame
        write_box(300, 300, 310, 310, 1'b1);
        check("shadow_pending_set", 32'(bus.box_pending), 32'd1);
        pixel("shadow_old_kept", 100, 50, BOX);
        pixel("shadow_new_hidden", 300, 300, BG);
        frame_start(1'b0, 0, 0, 0, 0, 1'b0);
        check("shadow_pending_clr", 32'(bus.box_pending), 32'd0);
        check("shadow_fc", 32'(bus.frame_cnt), 32'(exp_fc));
        pixel("shadow_new_shown", 300, 300, BOX);
        pixel("shadow_old_gone", 100, 50, BG);

        // Swapped corners give the same outline as the basic box
        write_box(200, 150, 100, 50, 1'b1);
        frame_start(1'b0, 0, 0, 0, 0, 1'b0);
        check("swap_fc", 32'(bus.frame_cnt), 32'(exp_fc));
        pixel("swap_100_50", 100, 50, BOX);
        pixel("swap_200_150", 200, 150, BOX);
        pixel("swap_199_120", 199, 120, BOX);
        pixel("swap_198_120", 198, 120, BG);
        pixel("swap_201_100", 201, 100, BG);

        // Tiny box: interior vanishes, every pixel is outline
        write_box(10, 10, 12, 12, 1'b1);
        frame_start(1'b0, 0, 0, 0, 0, 1'b0);
        for (int yy = 10; yy <= 12; yy++) begin
            for (int xx = 10; xx <= 12; xx++) begin
                pixel($sformatf("tiny_%0d_%0d", xx, yy), xx, yy,
                      (XH && (xx == 11 || yy == 11)) ? CROSS : BOX);
            end
        end
        pixel("tiny_13_11", 13, 11, BG);
        pixel("tiny_9_10", 9, 10, BG);

        // Collision: write on the fs cycle keeps the new box pending
        write_box(20, 20, 40, 40, 1'b1);
        frame_start(1'b1, 60, 60, 80, 80, 1'b1);
        check("coll_pending_kept", 32'(bus.box_pending), 32'd1);
        check("coll_fc", 32'(bus.frame_cnt), 32'(exp_fc));
        pixel("coll_old_applied", 20, 20, BOX);
        pixel("coll_new_hidden", 60, 60, BG);
        frame_start(1'b0, 0, 0, 0, 0, 1'b0);
        check("coll_pending_clr", 32'(bus.box_pending), 32'd0);
        check("coll_fc2", 32'(bus.frame_cnt), 32'(exp_fc));
        pixel("coll_new_applied", 60, 60, BOX);
        pixel("coll_old_gone", 20, 20, BG);

        // Disabled box draws nothing
        write_box(100, 50, 200, 150, 1'b0);
        frame_start(1'b0, 0, 0, 0, 0, 1'b0);
        pixel("dis_100_50", 100, 50, BG);
        pixel("dis_150_80", 150, 80, BG);

        // Mid-frame reset drops the active box and counter
        write_box(100, 50, 200, 150, 1'b1);
        frame_start(1'b0, 0, 0, 0, 0, 1'b0);
        check("pre_rst_fc", 32'(bus.frame_cnt), 32'(exp_fc));
        pixel("pre_rst_box", 100, 50, BOX);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        check("post_rst_fc", 32'(bus.frame_cnt), 32'd0);
        check("post_rst_pending", 32'(bus.box_pending), 32'd0);
        pixel("post_rst_no_box", 100, 50, BG);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
